// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the register file's single write port between three writeback
//   sources (0 = ALU, 1 = multdiv, 2 = load). One valid request is granted per
//   cycle by round-robin. The winner is registered onto the write port, and a
//   saturating counter records cycles in which some valid request waited.
//
// Optional feature: define WBARB_FWD_EN to add read-address inputs and
//   forwarding outputs that cover the window before the register file writes.
//
// Ports
//   clock            rising-edge clock
//   ctrl_reset       synchronous active-high reset
//   req_valid[2:0]   per-source request
//   req_addr         source i destination at [i*ADDR_W +: ADDR_W]
//   req_data         source i write data at [i*DATA_W +: DATA_W]
//   req_ready[2:0]   one-hot combinational grant
//   ctrl_writeEnable registered write enable (never set for r0)
//   ctrl_writeReg    registered write address
//   data_writeReg    registered write data
//   stall_cnt        saturating count of cycles with an ungranted valid request
//   ctrl_readRegA/B  read addresses               (WBARB_FWD_EN only)
//   fwd_hitA/B       forwarding hit                (WBARB_FWD_EN only)
//   fwd_dataA/B      forwarded data                (WBARB_FWD_EN only)
module regfile_wb_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                  clock,
  input  logic                  ctrl_reset,
  input  logic [2:0]            req_valid,
  input  logic [3*ADDR_W-1:0]   req_addr,
  input  logic [3*DATA_W-1:0]   req_data,
  output logic [2:0]            req_ready,
  output logic                  ctrl_writeEnable,
  output logic [ADDR_W-1:0]     ctrl_writeReg,
  output logic [DATA_W-1:0]     data_writeReg,
  output logic [CNT_W-1:0]      stall_cnt
`ifdef WBARB_FWD_EN
  ,
  input  logic [ADDR_W-1:0]     ctrl_readRegA,
  input  logic [ADDR_W-1:0]     ctrl_readRegB,
  output logic                  fwd_hitA,
  output logic                  fwd_hitB,
  output logic [DATA_W-1:0]     fwd_dataA,
  output logic [DATA_W-1:0]     fwd_dataB
`endif
);

  logic [1:0]        r_last;
  logic              r_wen;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic [1:0]        w_p0, w_p1, w_p2;
  logic [1:0]        w_gidx;
  logic              w_any;
  logic [2:0]        w_grant;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_data;
  logic              w_stall;

  // Priority order starts one past the last grant and wraps modulo 3.
  always_comb begin
    w_p0 = 2'd0;
    w_p1 = 2'd1;
    w_p2 = 2'd2;
    case (r_last)
      2'd0:    begin w_p0 = 2'd1; w_p1 = 2'd2; w_p2 = 2'd0; end
      2'd1:    begin w_p0 = 2'd2; w_p1 = 2'd0; w_p2 = 2'd1; end
      default: begin w_p0 = 2'd0; w_p1 = 2'd1; w_p2 = 2'd2; end
    endcase
  end

  // Reset masks every request so nothing is accepted while it is asserted.
  always_comb begin
    w_any  = 1'b0;
    w_gidx = 2'd0;
    if (!ctrl_reset) begin
      if (req_valid[w_p0]) begin
        w_any  = 1'b1;
        w_gidx = w_p0;
      end else if (req_valid[w_p1]) begin
        w_any  = 1'b1;
        w_gidx = w_p1;
      end else if (req_valid[w_p2]) begin
        w_any  = 1'b1;
        w_gidx = w_p2;
      end
    end
    w_grant = w_any ? (3'b001 << w_gidx) : 3'b000;
  end

  always_comb begin
    w_sel_addr = req_addr[0 +: ADDR_W];
    w_sel_data = req_data[0 +: DATA_W];
    case (w_gidx)
      2'd1: begin
        w_sel_addr = req_addr[ADDR_W +: ADDR_W];
        w_sel_data = req_data[DATA_W +: DATA_W];
      end
      2'd2: begin
        w_sel_addr = req_addr[2*ADDR_W +: ADDR_W];
        w_sel_data = req_data[2*DATA_W +: DATA_W];
      end
      default: begin
        w_sel_addr = req_addr[0 +: ADDR_W];
        w_sel_data = req_data[0 +: DATA_W];
      end
    endcase
  end

  // Two or more valid requests means at least one is left waiting.
  assign w_stall = (req_valid[0] & req_valid[1]) | (req_valid[0] & req_valid[2]) |
                   (req_valid[1] & req_valid[2]);

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      r_last      <= 2'd2;
      r_wen       <= 1'b0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_any) begin
        r_last  <= w_gidx;
        r_waddr <= w_sel_addr;
        r_wdata <= w_sel_data;
        // r0 writes consume the slot but never reach the register file.
        r_wen   <= (w_sel_addr != '0);
      end else begin
        r_wen <= 1'b0;
      end
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign req_ready        = w_grant;
  assign ctrl_writeEnable = r_wen;
  assign ctrl_writeReg    = r_waddr;
  assign data_writeReg    = r_wdata;
  assign stall_cnt        = r_stall_cnt;

`ifdef WBARB_FWD_EN
  assign fwd_hitA  = r_wen & (ctrl_readRegA == r_waddr);
  assign fwd_hitB  = r_wen & (ctrl_readRegB == r_waddr);
  assign fwd_dataA = r_wdata;
  assign fwd_dataB = r_wdata;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned CNT_W  = 4;

  logic                clock;
  logic                ctrl_reset;
  logic [2:0]          req_valid;
  logic [3*ADDR_W-1:0] req_addr;
  logic [3*DATA_W-1:0] req_data;
  logic [2:0]          req_ready;
  logic                ctrl_writeEnable;
  logic [ADDR_W-1:0]   ctrl_writeReg;
  logic [DATA_W-1:0]   data_writeReg;
  logic [CNT_W-1:0]    stall_cnt;
`ifdef WBARB_FWD_EN
  logic [ADDR_W-1:0]   ctrl_readRegA;
  logic [ADDR_W-1:0]   ctrl_readRegB;
  logic                fwd_hitA;
  logic                fwd_hitB;
  logic [DATA_W-1:0]   fwd_dataA;
  logic [DATA_W-1:0]   fwd_dataB;
`endif

  regfile_wb_arbiter #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clock            (clock),
    .ctrl_reset       (ctrl_reset),
    .req_valid        (req_valid),
    .req_addr         (req_addr),
    .req_data         (req_data),
    .req_ready        (req_ready),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .stall_cnt        (stall_cnt)
`ifdef WBARB_FWD_EN
    ,
    .ctrl_readRegA    (ctrl_readRegA),
    .ctrl_readRegB    (ctrl_readRegB),
    .fwd_hitA         (fwd_hitA),
    .fwd_hitB         (fwd_hitB),
    .fwd_dataA        (fwd_dataA),
    .fwd_dataB        (fwd_dataB)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        rst;
    logic [2:0]  v;
    logic [4:0]  a0, a1, a2;
    logic [31:0] d0, d1, d2;
    logic [2:0]  er;   // expected req_ready before the edge
    logic        ee;   // expected outputs after the edge
    logic [4:0]  ea;
    logic [31:0] ed;
    logic [3:0]  ec;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs at the falling edge and let combinational ready settle.
  task automatic apply(input logic rst, input logic [2:0] v,
                       input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
    @(negedge clock);
    ctrl_reset = rst;
    req_valid  = v;
    req_addr   = {a2, a1, a0};
    req_data   = {d2, d1, d0};
    #1;
  endtask

  task automatic after_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_out(input string name, input logic e, input logic [4:0] a,
                         input logic [31:0] d, input logic [3:0] c);
    chk({name, " en"},   64'(ctrl_writeEnable), 64'(e));
    chk({name, " reg"},  64'(ctrl_writeReg),    64'(a));
    chk({name, " data"}, 64'(data_writeReg),    64'(d));
    chk({name, " cnt"},  64'(stall_cnt),        64'(c));
  endtask

  initial begin
    //         rst   v       a0     a1     a2     d0            d1     d2
    //         er      ee    ea     ed            ec
    tbl[0]  = '{1'b0, 3'b001, 5'd5, 5'd0, 5'd0, 32'hDEADBEEF, 32'd0, 32'd0,
                3'b001, 1'b1, 5'd5, 32'hDEADBEEF, 4'd0};
    tbl[1]  = '{1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0,
                3'b000, 1'b0, 5'd5, 32'hDEADBEEF, 4'd0};
    tbl[2]  = '{1'b1, 3'b111, 5'd1, 5'd2, 5'd3, 32'd11, 32'd22, 32'd33,
                3'b000, 1'b0, 5'd0, 32'd0, 4'd0};
    tbl[3]  = '{1'b0, 3'b111, 5'd1, 5'd2, 5'd3, 32'd11, 32'd22, 32'd33,
                3'b001, 1'b1, 5'd1, 32'd11, 4'd1};
    tbl[4]  = '{1'b0, 3'b111, 5'd1, 5'd2, 5'd3, 32'd11, 32'd22, 32'd33,
                3'b010, 1'b1, 5'd2, 32'd22, 4'd2};
    tbl[5]  = '{1'b0, 3'b111, 5'd1, 5'd2, 5'd3, 32'd11, 32'd22, 32'd33,
                3'b100, 1'b1, 5'd3, 32'd33, 4'd3};
    tbl[6]  = '{1'b0, 3'b111, 5'd1, 5'd2, 5'd3, 32'd11, 32'd22, 32'd33,
                3'b001, 1'b1, 5'd1, 32'd11, 4'd4};
    tbl[7]  = '{1'b0, 3'b111, 5'd1, 5'd2, 5'd3, 32'd11, 32'd22, 32'd33,
                3'b010, 1'b1, 5'd2, 32'd22, 4'd5};
    tbl[8]  = '{1'b0, 3'b111, 5'd1, 5'd2, 5'd3, 32'd11, 32'd22, 32'd33,
                3'b100, 1'b1, 5'd3, 32'd33, 4'd6};
    tbl[9]  = '{1'b0, 3'b001, 5'd4, 5'd0, 5'd0, 32'd44, 32'd0, 32'd0,
                3'b001, 1'b1, 5'd4, 32'd44, 4'd6};
    // r0 write from the load path: slot used, no enable, pointer moves to 2.
    tbl[10] = '{1'b0, 3'b100, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'h1234,
                3'b100, 1'b0, 5'd0, 32'h1234, 4'd6};
    // Tie after the r0 write goes to source 0.
    tbl[11] = '{1'b0, 3'b011, 5'd1, 5'd2, 5'd0, 32'd11, 32'd22, 32'd0,
                3'b001, 1'b1, 5'd1, 32'd11, 4'd7};

    ctrl_reset = 1'b1;
    req_valid  = '0;
    req_addr   = '0;
    req_data   = '0;
`ifdef WBARB_FWD_EN
    ctrl_readRegA = '0;
    ctrl_readRegB = '0;
`endif
    repeat (2) @(posedge clock);
    #1;
    chk("reset ready", 64'(req_ready), 64'(3'b000));
    chk_out("reset", 1'b0, 5'd0, 32'd0, 4'd0);

    for (int i = 0; i < 12; i++) begin
      apply(tbl[i].rst, tbl[i].v, tbl[i].a0, tbl[i].a1, tbl[i].a2,
            tbl[i].d0, tbl[i].d1, tbl[i].d2);
      chk($sformatf("vec%0d ready", i), 64'(req_ready), 64'(tbl[i].er));
      after_edge();
      chk_out($sformatf("vec%0d", i), tbl[i].ee, tbl[i].ea, tbl[i].ed, tbl[i].ec);
    end

    // Saturation: two sources held for 20 cycles from a count of 7.
    for (int i = 0; i < 20; i++) begin
      apply(1'b0, 3'b011, 5'd1, 5'd2, 5'd0, 32'd11, 32'd22, 32'd0);
      after_edge();
    end
    chk("sat cnt", 64'(stall_cnt), 64'(4'd15));
    chk("sat en", 64'(ctrl_writeEnable), 64'(1'b1));

    // Reset mid-operation: leave the pointer at 0, then reset with a tie pending.
    apply(1'b0, 3'b001, 5'd9, 5'd0, 5'd0, 32'd99, 32'd0, 32'd0);
    chk("pre-rst ready", 64'(req_ready), 64'(3'b001));
    after_edge();
    chk_out("pre-rst", 1'b1, 5'd9, 32'd99, 4'd15);
    apply(1'b1, 3'b011, 5'd9, 5'd6, 5'd0, 32'd99, 32'd66, 32'd0);
    chk("in-rst ready", 64'(req_ready), 64'(3'b000));
    after_edge();
    chk_out("post-rst", 1'b0, 5'd0, 32'd0, 4'd0);
    apply(1'b0, 3'b011, 5'd9, 5'd6, 5'd0, 32'd99, 32'd66, 32'd0);
    chk("post-rst tie ready", 64'(req_ready), 64'(3'b001));
    after_edge();
    chk_out("post-rst tie", 1'b1, 5'd9, 32'd99, 4'd1);

`ifdef WBARB_FWD_EN
    ctrl_readRegA = 5'd7;
    ctrl_readRegB = 5'd8;
    apply(1'b0, 3'b001, 5'd7, 5'd0, 5'd0, 32'hA5A5A5A5, 32'd0, 32'd0);
    after_edge();
    chk("fwd hitA", 64'(fwd_hitA), 64'(1'b1));
    chk("fwd dataA", 64'(fwd_dataA), 64'(32'hA5A5A5A5));
    chk("fwd hitB", 64'(fwd_hitB), 64'(1'b0));
    ctrl_readRegA = 5'd0;
    ctrl_readRegB = 5'd0;
    apply(1'b0, 3'b001, 5'd0, 5'd0, 5'd0, 32'h5555, 32'd0, 32'd0);
    after_edge();
    chk("fwd r0 hitA", 64'(fwd_hitA), 64'(1'b0));
    chk("fwd r0 hitB", 64'(fwd_hitB), 64'(1'b0));
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
